multicycle_control: RTL and testbench

- Moore/Mealy sequencing FSM that drives a multi-cycle MIPS datapath built from the existing PC, register file, ALU, ALU control and memory blocks.
- One shared memory serves both instruction and data.
- Decodes the opcode from the instruction register and steps each instruction through 3-5 cycles.
- Stalls on a memory ready handshake and traps on illegal opcodes.

---
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle MIPS datapath (shared instruction/data memory).
// Define MC_JUMP_EN to decode J_OP into the JUMP state; otherwise J_OP traps as illegal.
`timescale 1ns/1ps
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  localparam logic [5:0] RTYPE_OP = 6'b000000;
  localparam logic [5:0] LW_OP    = 6'b100011;
  localparam logic [5:0] SW_OP    = 6'b101011;
  localparam logic [5:0] BEQ_OP   = 6'b000100;
  localparam logic [5:0] ADDI_OP  = 6'b001000;
`ifdef MC_JUMP_EN
  localparam logic [5:0] J_OP     = 6'b000010;
  localparam logic [3:0] S_JUMP   = 4'd11;
`endif

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_TRAP   = 4'd12;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_illegal;

  // illegal tracks entry into TRAP, which is only left through reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= (w_next == S_TRAP);
    end
  end

  // Next-state and control decode; FETCH strobes follow mem_ready (Mealy)
  always_comb begin
    w_next      = r_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    PCSource    = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          LW_OP, SW_OP: w_next = S_MEMADR;
          RTYPE_OP:     w_next = S_EXEC;
          BEQ_OP:       w_next = S_BRANCH;
          ADDI_OP:      w_next = S_ADDIEX;
`ifdef MC_JUMP_EN
          J_OP:         w_next = S_JUMP;
`endif
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == LW_OP)      w_next = S_MEMRD;
        else if (opcode == SW_OP) w_next = S_MEMWR;
        else                      w_next = S_TRAP;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
        w_next  = S_RTWB;
      end
      S_RTWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        w_next      = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        w_next   = S_FETCH;
      end
`endif
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  assign illegal   = r_illegal;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, corner sequences,
// and randomized instruction streams against a path-based reference model.
`timescale 1ns/1ps
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state_dbg;

  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] AI = 6'b001000;
  localparam logic [5:0] JP = 6'b000010;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       ill;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic       irw;
    logic       rw;
    logic       mw;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
  } vec_t;

  int total = 0;
  int bad = 0;
  vec_t tbl[$];
  logic [3:0] path[$];

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Control word each state must present, straight from the state table
  function automatic out_t exp_out(input logic [3:0] st, input logic rdy);
    out_t o;
    o = '0;
    case (st)
      4'd0:  begin o.mrd = 1'b1; o.srcb = 2'b01; o.irw = rdy; o.pcw = rdy; end
      4'd1:  o.srcb = 2'b11;
      4'd2:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      4'd3:  begin o.mrd = 1'b1; o.iord = 1'b1; end
      4'd4:  begin o.m2r = 1'b1; o.rw = 1'b1; end
      4'd5:  begin o.mwr = 1'b1; o.iord = 1'b1; end
      4'd6:  begin o.srca = 1'b1; o.aluop = 3'b010; end
      4'd7:  begin o.rdst = 1'b1; o.rw = 1'b1; end
      4'd8:  begin o.srca = 1'b1; o.aluop = 3'b001; o.pcwc = 1'b1; o.pcsrc = 2'b01; end
      4'd9:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      4'd10: o.rw = 1'b1;
      4'd11: begin o.pcw = 1'b1; o.pcsrc = 2'b10; end
      4'd12: o.ill = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // State walk of one instruction (FETCH first, no stalls)
  function automatic void build_path(input logic [5:0] op);
    path.delete();
    path.push_back(4'd0);
    path.push_back(4'd1);
    case (op)
      LW: begin path.push_back(4'd2); path.push_back(4'd3); path.push_back(4'd4); end
      SW: begin path.push_back(4'd2); path.push_back(4'd5); end
      RT: begin path.push_back(4'd6); path.push_back(4'd7); end
      BQ: path.push_back(4'd8);
      AI: begin path.push_back(4'd9); path.push_back(4'd10); end
`ifdef MC_JUMP_EN
      JP: path.push_back(4'd11);
`endif
      default: path.push_back(4'd12);
    endcase
  endfunction

  task automatic check(input string name, input logic [3:0] st, input logic rdy);
    out_t got, exp;
    got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};
    exp = exp_out(st, rdy);
    total++;
    if (state_dbg !== st || got !== exp) begin
      bad++;
      $display("FAIL %s: state=%0d want=%0d ctrl=%h want=%h", name, state_dbg, st, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic cyc(input string name, input logic [5:0] op, input logic rdy, input logic [3:0] st);
    opcode = op;
    mem_ready = rdy;
    #1;
    check(name, st, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("reset", 4'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int idx;
    int trap_cnt;
    logic [5:0] cur_op;
    logic [3:0] st;
    logic rdy;

    tbl.push_back('{LW, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{LW, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{LW, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{LW, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{LW, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{RT, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{RT, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{RT, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{RT, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{RT, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{RT, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 3'b010, 2'b00});
    tbl.push_back('{RT, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{SW, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{SW, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{SW, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{SW, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00});
    tbl.push_back('{SW, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00});
    tbl.push_back('{SW, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00});
    tbl.push_back('{BQ, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{BQ, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{BQ, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 3'b001, 2'b01});
    tbl.push_back('{AI, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{AI, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{AI, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00});
    tbl.push_back('{AI, 1'b0, 4'd10, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00});

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      opcode = tbl[i].op;
      mem_ready = tbl[i].rdy;
      #1;
      total++;
      if (state_dbg !== tbl[i].st || IRWrite !== tbl[i].irw || RegWrite !== tbl[i].rw ||
          MemWrite !== tbl[i].mw || ALUOp !== tbl[i].aluop || PCSource !== tbl[i].pcsrc) begin
        bad++;
        $display("FAIL table[%0d]: st=%0d irw=%b rw=%b mw=%b aluop=%b pcsrc=%b want st=%0d irw=%b rw=%b mw=%b aluop=%b pcsrc=%b",
                 i, state_dbg, IRWrite, RegWrite, MemWrite, ALUOp, PCSource,
                 tbl[i].st, tbl[i].irw, tbl[i].rw, tbl[i].mw, tbl[i].aluop, tbl[i].pcsrc);
      end
      @(negedge clk);
    end

    // Illegal opcode traps and stays trapped until reset
    do_reset();
    cyc("trap_fetch", 6'b111111, 1'b1, 4'd0);
    cyc("trap_decode", 6'b111111, 1'b1, 4'd1);
    for (int k = 0; k < 10; k++) cyc("trap_hold", 6'($urandom), 1'($urandom), 4'd12);
    do_reset();

    // Jump opcode: JUMP state when enabled, trap otherwise
    cyc("j_fetch", JP, 1'b1, 4'd0);
    cyc("j_decode", JP, 1'b1, 4'd1);
`ifdef MC_JUMP_EN
    cyc("j_jump", JP, 1'b1, 4'd11);
    cyc("j_back", JP, 1'b0, 4'd0);
`else
    cyc("j_trap", JP, 1'b1, 4'd12);
    cyc("j_trap2", JP, 1'b0, 4'd12);
`endif
    do_reset();

    // Asynchronous reset during RTWB must drop RegWrite immediately
    cyc("rst_mid_f", RT, 1'b1, 4'd0);
    cyc("rst_mid_d", RT, 1'b1, 4'd1);
    cyc("rst_mid_e", RT, 1'b1, 4'd6);
    #1;
    check("rst_mid_wb", 4'd7, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", 4'd0, 1'b1);
    @(negedge clk);
    do_reset();

    // Randomized instruction stream against the path model
    trap_cnt = 0;
    cur_op = LW;
    build_path(cur_op);
    idx = 0;
    for (int c = 0; c < 2000; c++) begin
      st = path[idx];
      rdy = ($urandom_range(0, 3) != 0);
      cyc("random", (st == 4'd0) ? 6'($urandom) : cur_op, rdy, st);
      if (st == 4'd12) begin
        trap_cnt++;
        if (trap_cnt == 3) begin
          do_reset();
          trap_cnt = 0;
          idx = path.size();
        end
      end else if (!((st == 4'd0 || st == 4'd3 || st == 4'd5) && !rdy)) begin
        idx++;
      end
      if (idx >= path.size()) begin
        case ($urandom_range(0, 7))
          0: cur_op = LW;
          1: cur_op = SW;
          2: cur_op = RT;
          3: cur_op = BQ;
          4: cur_op = AI;
          5: cur_op = JP;
          6: cur_op = LW;
          default: cur_op = 6'($urandom);
        endcase
        build_path(cur_op);
        idx = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
